// File: rtl/bottleneck_seq.sv
// -----------------------------------------------------------------------------
// bottleneck_seq
//
// Splits 32- and 64-bit CPU bus transfers into aligned 16-bit beats for the
// downstream 64-to-16-bit bus bottleneck, and reassembles read data into a
// single right-justified result. 8- and 16-bit transfers pass straight through
// with no added latency. Transfers are little-endian: beat 0 targets the lowest
// address and carries the least-significant halfword.
//
// Ports
//   clk_i, reset_ni          clock (rising edge) and async active-low reset
//   m_adr_i / m_cyc_i / m_stb_i / m_we_i / m_signed_i / m_siz_i / m_dat_i
//                            CPU-side request (siz: 00=8, 01=16, 10=32, 11=64)
//   m_ack_o / m_dat_o / m_err_align_o
//                            CPU-side completion, read data, misalignment flag
//   d_adr_o / d_cyc_o / d_stb_o / d_we_o / d_signed_o / d_siz_o / d_dat_o
//                            request towards the bottleneck's master port
//   d_ack_i / d_dat_i / d_err_align_i
//                            completion from the bottleneck
//
// While reset_ni is low every output is held at 0 regardless of inputs.
// -----------------------------------------------------------------------------
module bottleneck_seq (
  input  logic        clk_i,
  input  logic        reset_ni,

  input  logic [63:0] m_adr_i,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic        m_we_i,
  input  logic        m_signed_i,
  input  logic [1:0]  m_siz_i,
  input  logic [63:0] m_dat_i,
  output logic        m_ack_o,
  output logic [63:0] m_dat_o,
  output logic        m_err_align_o,

  output logic [63:0] d_adr_o,
  output logic        d_cyc_o,
  output logic        d_stb_o,
  output logic        d_we_o,
  output logic        d_signed_o,
  output logic [1:0]  d_siz_o,
  output logic [63:0] d_dat_o,
  input  logic        d_ack_i,
  input  logic [63:0] d_dat_i,
  input  logic        d_err_align_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  k_reg, k_next;

  // Read reassembly buffer, one halfword per beat.
  logic [3:0]  buf_load;
  logic [63:0] buf_flat;

  logic        req;
  logic        wide;
  logic        misaligned;
  logic        last_beat;

  // Unmasked output values; the reset mask is applied at the ports.
  logic        m_ack_comb;
  logic [63:0] m_dat_comb;
  logic        m_err_comb;
  logic [63:0] d_adr_comb;
  logic        d_cyc_comb;
  logic        d_stb_comb;
  logic        d_we_comb;
  logic        d_signed_comb;
  logic [1:0]  d_siz_comb;
  logic [63:0] d_dat_comb;

  assign req  = m_cyc_i & m_stb_i;
  assign wide = m_siz_i[1];

  // 64-bit needs 8-byte alignment, 32-bit needs 4-byte alignment.
  assign misaligned = m_siz_i[0] ? (m_adr_i[2:0] != 3'd0)
                                 : (m_adr_i[1:0] != 2'd0);

  // Final beat index is N-1: 1 for 32-bit, 3 for 64-bit.
  assign last_beat = (k_reg == {m_siz_i[0], 1'b1});

  // ---------------------------------------------------------------------------
  // State and beat counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg <= ST_IDLE;
      k_reg     <= 2'd0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Halfword buffer: each slot captures d_dat_i[15:0] on its own read beat.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_buf
      logic [15:0] hw_reg;

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          hw_reg <= 16'd0;
        end else if (buf_load[gi]) begin
          hw_reg <= d_dat_i[15:0];
        end
      end

      assign buf_flat[16*gi +: 16] = hw_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    buf_load      = 4'd0;

    m_ack_comb    = 1'b0;
    m_dat_comb    = 64'd0;
    m_err_comb    = 1'b0;
    d_adr_comb    = 64'd0;
    d_cyc_comb    = 1'b0;
    d_stb_comb    = 1'b0;
    d_we_comb     = 1'b0;
    d_signed_comb = 1'b0;
    d_siz_comb    = 2'b00;
    d_dat_comb    = 64'd0;

    unique case (state_reg)
      ST_IDLE: begin
        k_next = 2'd0;
        if (req && wide) begin
          // Wide request: nothing goes downstream in this cycle.
          if (misaligned) begin
            m_err_comb = 1'b1;
          end else begin
            state_next = ST_BEAT;
          end
        end else begin
          // Narrow (or no) request: transparent wiring in both directions.
          d_adr_comb    = m_adr_i;
          d_cyc_comb    = m_cyc_i;
          d_stb_comb    = m_stb_i;
          d_we_comb     = m_we_i;
          d_signed_comb = m_signed_i;
          d_siz_comb    = m_siz_i;
          d_dat_comb    = m_dat_i;
          m_ack_comb    = d_ack_i;
          m_dat_comb    = d_dat_i;
          m_err_comb    = d_err_align_i;
        end
      end

      ST_BEAT: begin
        d_adr_comb = m_adr_i + {61'd0, k_reg, 1'b0};
        d_siz_comb = 2'b01;
        d_we_comb  = m_we_i;
        d_dat_comb = {48'd0, m_dat_i[{k_reg, 4'b0000} +: 16]};

        if (!m_cyc_i) begin
          // Master abandoned the cycle: drop the bus now, discard progress.
          state_next = ST_IDLE;
          k_next     = 2'd0;
        end else begin
          d_cyc_comb = 1'b1;
          d_stb_comb = m_stb_i;
          // The alignment error input is ignored here: beats are aligned.
          if (d_ack_i) begin
            if (!m_we_i) begin
              buf_load[k_reg] = 1'b1;
            end
            if (last_beat) begin
              state_next = ST_DONE;
            end else begin
              k_next = k_reg + 2'd1;
            end
          end
        end
      end

      ST_DONE: begin
        m_ack_comb = 1'b1;
        state_next = ST_IDLE;
        k_next     = 2'd0;
        if (!m_we_i) begin
          if (m_siz_i[0]) begin
            m_dat_comb = buf_flat;
          end else begin
            m_dat_comb = {{32{m_signed_i & buf_flat[31]}}, buf_flat[31:0]};
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        k_next     = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs are forced low for as long as reset is held.
  // ---------------------------------------------------------------------------
  assign m_ack_o       = reset_ni & m_ack_comb;
  assign m_dat_o       = reset_ni ? m_dat_comb : 64'd0;
  assign m_err_align_o = reset_ni & m_err_comb;
  assign d_adr_o       = reset_ni ? d_adr_comb : 64'd0;
  assign d_cyc_o       = reset_ni & d_cyc_comb;
  assign d_stb_o       = reset_ni & d_stb_comb;
  assign d_we_o        = reset_ni & d_we_comb;
  assign d_signed_o    = reset_ni & d_signed_comb;
  assign d_siz_o       = reset_ni ? d_siz_comb : 2'b00;
  assign d_dat_o       = reset_ni ? d_dat_comb : 64'd0;

endmodule

// File: tb/tb_bottleneck_seq.sv
// -----------------------------------------------------------------------------
// tb_bottleneck_seq
//
// Self-checking bench for bottleneck_seq. Narrow pass-through is covered by a
// table of vectors; wide transfers, misalignment, abort and mid-sequence reset
// by hand-written sequences. Expected read data for every acked transfer is
// queued when the request is driven and compared when m_ack_o appears.
// -----------------------------------------------------------------------------
module tb_bottleneck_seq;

  logic        clk = 1'b0;
  logic        reset_ni;

  logic [63:0] m_adr;
  logic        m_cyc, m_stb, m_we, m_signed;
  logic [1:0]  m_siz;
  logic [63:0] m_dat_w;
  logic        m_ack_o;
  logic [63:0] m_dat_o;
  logic        m_err_align_o;

  logic [63:0] d_adr_o;
  logic        d_cyc_o, d_stb_o, d_we_o, d_signed_o;
  logic [1:0]  d_siz_o;
  logic [63:0] d_dat_o;
  logic        d_ack;
  logic [63:0] d_dat_r;
  logic        d_err;

  int          checks = 0;
  int          passes = 0;
  logic [63:0] exp_q[$];

  bottleneck_seq dut (
    .clk_i         (clk),
    .reset_ni      (reset_ni),
    .m_adr_i       (m_adr),
    .m_cyc_i       (m_cyc),
    .m_stb_i       (m_stb),
    .m_we_i        (m_we),
    .m_signed_i    (m_signed),
    .m_siz_i       (m_siz),
    .m_dat_i       (m_dat_w),
    .m_ack_o       (m_ack_o),
    .m_dat_o       (m_dat_o),
    .m_err_align_o (m_err_align_o),
    .d_adr_o       (d_adr_o),
    .d_cyc_o       (d_cyc_o),
    .d_stb_o       (d_stb_o),
    .d_we_o        (d_we_o),
    .d_signed_o    (d_signed_o),
    .d_siz_o       (d_siz_o),
    .d_dat_o       (d_dat_o),
    .d_ack_i       (d_ack),
    .d_dat_i       (d_dat_r),
    .d_err_align_i (d_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  siz;
    logic        we;
    logic        sgn;
    logic [63:0] adr;
    logic [63:0] wdat;
    logic        dack;
    logic [63:0] ddat;
    logic        derr;
    logic        exp_ack;
    logic [63:0] exp_mdat;
    logic        exp_err;
    logic [63:0] exp_dadr;
    logic [63:0] exp_ddat;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
  endtask

  // Wait for the sampling edge, then run the ack scoreboard.
  task automatic sample();
    logic [63:0] e;
    @(negedge clk);
    if (m_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ack: got m_ack_o=1, expected 0 (nothing pending)");
      end else begin
        e = exp_q.pop_front();
        chk("ack_data", m_dat_o, e);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_signed = 1'b0;
    m_siz = 2'b00; m_adr = 64'd0; m_dat_w = 64'd0;
    d_ack = 1'b0; d_dat_r = 64'd0; d_err = 1'b0;
  endtask

  function automatic logic any_out();
    return |{m_ack_o, m_dat_o, m_err_align_o, d_adr_o, d_cyc_o, d_stb_o,
             d_we_o, d_signed_o, d_siz_o, d_dat_o};
  endfunction

  // One complete wide transfer. hw holds the halfwords the bottleneck returns
  // (beat 0 in bits 15:0); waits[k] inserts one wait state before beat k acks.
  task automatic run_wide(input string tag, input logic [63:0] adr, input logic is64,
                          input logic we, input logic sgn, input logic [63:0] wdat,
                          input logic [63:0] hw, input logic [3:0] waits,
                          input logic [63:0] exp_dat);
    int n;
    n = is64 ? 4 : 2;
    m_adr = adr; m_siz = {1'b1, is64}; m_we = we; m_signed = sgn; m_dat_w = wdat;
    m_cyc = 1'b1; m_stb = 1'b1;
    d_ack = 1'b0; d_dat_r = 64'd0; d_err = 1'b0;
    exp_q.push_back(exp_dat);
    sample();
    chk({tag, "_c0_dcyc"}, 64'(d_cyc_o), 64'd0);
    chk({tag, "_c0_ack"}, 64'(m_ack_o), 64'd0);
    adv();
    for (int k = 0; k < n; k++) begin
      if (waits[k]) begin
        d_ack = 1'b0;
        sample();
        chk({tag, "_wait_stb"}, 64'(d_stb_o), 64'd1);
        chk({tag, "_wait_adr"}, d_adr_o, adr + 64'(2 * k));
        chk({tag, "_wait_ack"}, 64'(m_ack_o), 64'd0);
        adv();
      end
      d_ack = 1'b1;
      d_dat_r = {48'hA5A5_A5A5_A5A5, hw[16*k +: 16]};
      d_err = 1'b1;
      sample();
      chk({tag, "_beat_adr"}, d_adr_o, adr + 64'(2 * k));
      chk({tag, "_beat_siz"}, 64'(d_siz_o), 64'd1);
      chk({tag, "_beat_we"}, 64'(d_we_o), 64'(we));
      chk({tag, "_beat_cyc"}, 64'(d_cyc_o), 64'd1);
      if (we) chk({tag, "_beat_wdat"}, d_dat_o, {48'd0, wdat[16*k +: 16]});
      chk({tag, "_beat_ack"}, 64'(m_ack_o), 64'd0);
      chk({tag, "_beat_err"}, 64'(m_err_align_o), 64'd0);
      adv();
    end
    d_ack = 1'b0; d_err = 1'b0; d_dat_r = 64'd0;
    sample();
    chk({tag, "_done_ack"}, 64'(m_ack_o), 64'd1);
    chk({tag, "_done_dcyc"}, 64'(d_cyc_o), 64'd0);
    adv();
    idle_bus();
    sample();
    chk({tag, "_ack_one_cycle"}, 64'(m_ack_o), 64'd0);
    adv();
    $display("txn %s: adr=0x%0h size=%0d we=%0d signed=%0d expected data=0x%016h",
             tag, adr, is64 ? 64 : 32, we, sgn, exp_dat);
  endtask

  initial begin
    // Narrow pass-through vectors (one cycle each, combinational path).
    vecs[0] = '{siz:2'b01, we:1'b0, sgn:1'b1, adr:64'h100, wdat:64'd0,
                dack:1'b1, ddat:64'hFFFF_FFFF_FFFF_8001, derr:1'b0,
                exp_ack:1'b1, exp_mdat:64'hFFFF_FFFF_FFFF_8001, exp_err:1'b0,
                exp_dadr:64'h100, exp_ddat:64'd0};
    vecs[1] = '{siz:2'b00, we:1'b1, sgn:1'b0, adr:64'h7, wdat:64'hA5,
                dack:1'b1, ddat:64'd0, derr:1'b0,
                exp_ack:1'b1, exp_mdat:64'd0, exp_err:1'b0,
                exp_dadr:64'h7, exp_ddat:64'hA5};
    vecs[2] = '{siz:2'b01, we:1'b0, sgn:1'b0, adr:64'h202, wdat:64'd0,
                dack:1'b0, ddat:64'h1234, derr:1'b0,
                exp_ack:1'b0, exp_mdat:64'h1234, exp_err:1'b0,
                exp_dadr:64'h202, exp_ddat:64'd0};
    vecs[3] = '{siz:2'b01, we:1'b0, sgn:1'b0, adr:64'h301, wdat:64'd0,
                dack:1'b0, ddat:64'd0, derr:1'b1,
                exp_ack:1'b0, exp_mdat:64'd0, exp_err:1'b1,
                exp_dadr:64'h301, exp_ddat:64'd0};

    // Reset: outputs forced to zero even with an active narrow request.
    reset_ni = 1'b0;
    idle_bus();
    m_cyc = 1'b1; m_stb = 1'b1; m_siz = 2'b01; m_adr = 64'h100; m_dat_w = 64'h55;
    d_ack = 1'b1; d_dat_r = '1; d_err = 1'b1;
    #3;
    chk("rst_outputs_zero", 64'(any_out()), 64'd0);
    idle_bus();
    @(negedge clk);
    reset_ni = 1'b1;
    adv();

    // Narrow table.
    for (int i = 0; i < 4; i++) begin
      m_siz = vecs[i].siz; m_we = vecs[i].we; m_signed = vecs[i].sgn;
      m_adr = vecs[i].adr; m_dat_w = vecs[i].wdat; m_cyc = 1'b1; m_stb = 1'b1;
      d_ack = vecs[i].dack; d_dat_r = vecs[i].ddat; d_err = vecs[i].derr;
      if (vecs[i].exp_ack) exp_q.push_back(vecs[i].exp_mdat);
      sample();
      chk("narrow_ack", 64'(m_ack_o), 64'(vecs[i].exp_ack));
      chk("narrow_err", 64'(m_err_align_o), 64'(vecs[i].exp_err));
      chk("narrow_mdat", m_dat_o, vecs[i].exp_mdat);
      chk("narrow_dadr", d_adr_o, vecs[i].exp_dadr);
      chk("narrow_ddat", d_dat_o, vecs[i].exp_ddat);
      chk("narrow_dcyc", 64'(d_cyc_o), 64'd1);
      $display("txn narrow[%0d]: siz=%0d adr=0x%0h ack=%0b data=0x%016h",
               i, vecs[i].siz, vecs[i].adr, m_ack_o, m_dat_o);
      adv();
    end
    idle_bus();
    adv();

    // Wide transfers.
    run_wide("rd64", 64'h2000, 1'b1, 1'b0, 1'b0, 64'd0,
             64'h4444_3333_2222_1111, 4'b0000, 64'h4444_3333_2222_1111);
    run_wide("rd32s", 64'h40, 1'b0, 1'b0, 1'b1, 64'd0,
             64'h0000_0000_9ABC_5678, 4'b0001, 64'hFFFF_FFFF_9ABC_5678);
    run_wide("rd32u", 64'h40, 1'b0, 1'b0, 1'b0, 64'd0,
             64'h0000_0000_9ABC_5678, 4'b0001, 64'h0000_0000_9ABC_5678);
    run_wide("wr64", 64'h1000, 1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D,
             64'h7777_6666_5555_4444, 4'b0100, 64'd0);

    // Misaligned wide requests: error flag, nothing downstream, no ack.
    m_adr = 64'h42; m_siz = 2'b10; m_cyc = 1'b1; m_stb = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("mis32_err", 64'(m_err_align_o), 64'd1);
      chk("mis32_dcyc", 64'(d_cyc_o), 64'd0);
      chk("mis32_ack", 64'(m_ack_o), 64'd0);
      adv();
    end
    m_adr = 64'h44; m_siz = 2'b11;
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("mis64_err", 64'(m_err_align_o), 64'd1);
      chk("mis64_dcyc", 64'(d_cyc_o), 64'd0);
      adv();
    end
    $display("txn misaligned: 32-bit @0x42 and 64-bit @0x44 held");
    idle_bus();
    adv();

    // Abort: 64-bit read, cycle dropped after the beat-1 ack.
    m_adr = 64'h2000; m_siz = 2'b11; m_cyc = 1'b1; m_stb = 1'b1;
    sample(); adv();
    d_ack = 1'b1; d_dat_r = 64'h1111;
    sample(); adv();
    d_dat_r = 64'h2222;
    sample();
    chk("abort_beat1_adr", d_adr_o, 64'h2002);
    adv();
    m_cyc = 1'b0; m_stb = 1'b0; d_ack = 1'b0;
    sample();
    chk("abort_dcyc", 64'(d_cyc_o), 64'd0);
    chk("abort_dstb", 64'(d_stb_o), 64'd0);
    chk("abort_ack", 64'(m_ack_o), 64'd0);
    adv();
    idle_bus();
    sample();
    chk("abort_no_late_ack", 64'(m_ack_o), 64'd0);
    adv();
    $display("txn abort: 64-bit read @0x2000 dropped after beat 1");
    run_wide("rd32_after_abort", 64'h80, 1'b0, 1'b0, 1'b0, 64'd0,
             64'h0000_0000_8002_0001, 4'b0000, 64'h0000_0000_8002_0001);

    // Reset asserted mid-beat.
    m_adr = 64'h3000; m_siz = 2'b11; m_we = 1'b1; m_dat_w = 64'h0123_4567_89AB_CDEF;
    m_cyc = 1'b1; m_stb = 1'b1;
    sample(); adv();
    sample();
    chk("rstmid_in_beat", 64'(d_cyc_o), 64'd1);
    adv();
    #2;
    reset_ni = 1'b0;
    #1;
    chk("rstmid_outputs_zero", 64'(any_out()), 64'd0);
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
    sample();
    chk("rstmid_idle_dcyc", 64'(d_cyc_o), 64'd0);
    chk("rstmid_idle_ack", 64'(m_ack_o), 64'd0);
    idle_bus();
    adv();
    sample();
    chk("rstmid_no_ack", 64'(m_ack_o), 64'd0);
    adv();
    $display("txn reset mid-beat: 64-bit write @0x3000 discarded");
    run_wide("rd32s_after_reset", 64'h84, 1'b0, 1'b0, 1'b1, 64'd0,
             64'h0000_0000_7FFF_0002, 4'b0000, 64'h0000_0000_7FFF_0002);

    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL missing_ack: got %0d pending transfers, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
